// File: rtl/mult_lut_pkg.sv
// Shared types and defaults for the LUT-based multiplier controller.
package mult_lut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int N_DEF       = 2;
    localparam int RD_LAT_DEF  = 1;
    localparam int ACC_GUARD_W = 4;

endpackage

// File: rtl/mult_lut_ctrl.sv
// Controller that looks up a*b in an external product ROM and returns it over a valid/ready handshake.
// Optional running accumulator of captured products when MULT_LUT_ACC_EN is defined.
module mult_lut_ctrl
    import mult_lut_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] rom_addr,
    output logic           rom_en,
    output logic           rom_read_en,
    input  logic [2*N-1:0] rom_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
`ifdef MULT_LUT_ACC_EN
    ,
    input  logic                       acc_clr,
    output logic [2*N+ACC_GUARD_W-1:0] acc_out
`endif
);

    // Wide enough for the largest supported read latency (15).
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   addr_q, addr_d;
    logic [2*N-1:0]   prod_q, prod_d;
    logic             xfer;
    logic             capture;

    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign xfer     = in_valid && in_ready;

    // A transfer is only possible from IDLE or a draining HOLD, so it always restarts READ.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        prod_d  = prod_q;
        capture = 1'b0;
        if (xfer) begin
            state_d = READ;
            cnt_d   = CNT_LOAD;
            addr_d  = {a, b};
        end else begin
            case (state_q)
                READ: begin
                    if (cnt_q == '0) begin
                        prod_d  = rom_data;
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            prod_q  <= prod_d;
        end
    end

    assign rom_en      = (state_q == READ);
    assign rom_read_en = (state_q == READ);
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign rom_addr    = addr_q;
    assign product     = prod_q;

`ifdef MULT_LUT_ACC_EN
    logic [2*N+ACC_GUARD_W-1:0] acc_q;

    // Clear wins over an add landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (capture) begin
            acc_q <= acc_q + {{ACC_GUARD_W{1'b0}}, rom_data};
        end
    end

    assign acc_out = acc_q;
`endif

endmodule

// File: tb/tb_mult_lut_ctrl.sv
// Scoreboard bench for mult_lut_ctrl: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_mult_lut_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Instance 0: N=2, RD_LAT=1
    logic       rst0_n, iv0, ir0, en0, ren0, ov0, or0, busy0;
    logic [1:0] a0, b0;
    logic [3:0] addr0, rd0, prod0;
    // Instance 1: N=2, RD_LAT=3
    logic       rst1_n, iv1, ir1, en1, ren1, ov1, or1, busy1;
    logic [1:0] a1, b1;
    logic [3:0] addr1, rd1, prod1;
`ifdef MULT_LUT_ACC_EN
    logic       acc_clr0, acc_clr1;
    logic [7:0] acc_out0, acc_out1;
`endif

    int         xq0[$], xq1[$];
    logic [3:0] pq0[$], pq1[$];
    logic       ov0_prev = 1'b0, ov1_prev = 1'b0;
    logic       b2b = 1'b0;
    int         last_rise1 = -1;

    function automatic logic [3:0] rom_model(input logic en, input logic ren, input logic [3:0] ad);
        logic [3:0] x, y;
        x = {2'b00, ad[3:2]};
        y = {2'b00, ad[1:0]};
        return (en && ren) ? x * y : 4'd0;
    endfunction

    assign rd0 = rom_model(en0, ren0, addr0);
    assign rd1 = rom_model(en1, ren1, addr1);

    mult_lut_ctrl #(.N(2), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst0_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .rom_addr(addr0), .rom_en(en0), .rom_read_en(ren0), .rom_data(rd0),
        .out_valid(ov0), .out_ready(or0), .product(prod0), .busy(busy0)
`ifdef MULT_LUT_ACC_EN
        , .acc_clr(acc_clr0), .acc_out(acc_out0)
`endif
    );

    mult_lut_ctrl #(.N(2), .RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .rom_addr(addr1), .rom_en(en1), .rom_read_en(ren1), .rom_data(rd1),
        .out_valid(ov1), .out_ready(or1), .product(prod1), .busy(busy1)
`ifdef MULT_LUT_ACC_EN
        , .acc_clr(acc_clr1), .acc_out(acc_out1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Pending results are discarded by a reset.
    initial forever @(negedge rst0_n) begin xq0.delete(); pq0.delete(); end
    initial forever @(negedge rst1_n) begin xq1.delete(); pq1.delete(); last_rise1 = -1; end

    // Monitor: records transfers, checks latency, spacing and products on handshake.
    initial forever begin
        @(negedge clk);
        if (rst0_n) begin
            if (iv0 && ir0) xq0.push_back(cyc);
            if (ov0 && !ov0_prev) begin
                chk("ov0_has_pending_xfer", xq0.size() != 0, 1);
                if (xq0.size() != 0) chk("latency0", cyc - xq0.pop_front(), 2);
            end
            if (ov0 && or0) begin
                chk("res0_expected", pq0.size() != 0, 1);
                if (pq0.size() != 0) chk("product0", prod0, pq0.pop_front());
            end
        end
        if (rst1_n) begin
            if (iv1 && ir1) xq1.push_back(cyc);
            if (pq1.size() != 0 && !busy1) chk("b2b_no_idle", busy1, 1);
            if (ov1 && !ov1_prev) begin
                chk("ov1_has_pending_xfer", xq1.size() != 0, 1);
                if (xq1.size() != 0) chk("latency1", cyc - xq1.pop_front(), 4);
                if (b2b && last_rise1 >= 0) chk("b2b_interval", cyc - last_rise1, 4);
                last_rise1 = cyc;
            end
            if (ov1 && or1) begin
                chk("res1_expected", pq1.size() != 0, 1);
                if (pq1.size() != 0) chk("product1", prod1, pq1.pop_front());
            end
        end
        ov0_prev = ov0;
        ov1_prev = ov1;
    end

    // Returns #1 after the transfer edge.
    task automatic send0(input logic [1:0] a, input logic [1:0] b, input logic [3:0] e);
        logic got;
        int   n;
        a0 = a; b0 = b; iv0 = 1'b1; n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); got = ir0;
            @(posedge clk); #1; n++;
        end
        if (!got) chk("send0_timeout", got, 1);
        else pq0.push_back(e);
        iv0 = 1'b0;
    endtask

    task automatic send1(input logic [1:0] a, input logic [1:0] b, input logic [3:0] e, input logic keep);
        logic got;
        int   n;
        a1 = a; b1 = b; iv1 = 1'b1; n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); got = ir1;
            @(posedge clk); #1; n++;
        end
        if (!got) chk("send1_timeout", got, 1);
        else pq1.push_back(e);
        if (!keep) iv1 = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        while (pq0.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain0_done", pq0.size(), 0);
    endtask

    task automatic drain1();
        int n = 0;
        while (pq1.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain1_done", pq1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ovcnt;
        rst0_n = 1'b0; rst1_n = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        or0 = 1'b1; or1 = 1'b1;
`ifdef MULT_LUT_ACC_EN
        acc_clr0 = 1'b0; acc_clr1 = 1'b0;
`endif
        #12;
        chk("rst_busy0", busy0, 0);
        chk("rst_rom_en0", en0, 0);
        chk("rst_rom_read_en0", ren0, 0);
        chk("rst_out_valid0", ov0, 0);
        chk("rst_addr0", addr0, 0);
        chk("rst_prod0", prod0, 0);
        chk("rst_busy1", busy1, 0);
`ifdef MULT_LUT_ACC_EN
        chk("rst_acc0", acc_out0, 0);
`endif
        @(posedge clk); #1;
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready0", ir0, 1);

        // Single multiply 2*3
        send0(2'd2, 2'd3, 4'd6);
        chk("addr_2x3", addr0, 4'b1011);
        chk("rom_en_in_read", en0, 1);
        chk("rom_read_en_in_read", ren0, 1);
        drain0();
        chk("back_idle_busy0", busy0, 0);
        chk("back_idle_in_ready0", ir0, 1);

        // Boundary products
        send0(2'd3, 2'd3, 4'd9);
        send0(2'd0, 2'd3, 4'd0);
        send0(2'd3, 2'd2, 4'd6);
        drain0();

        // Backpressure: result must hold, operands and in_valid ignored
        or0 = 1'b0;
        send0(2'd1, 2'd3, 4'd3);
        n = 0;
        while (!ov0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_reached_hold", ov0, 1);
        iv0 = 1'b1; a0 = 2'd3; b0 = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", ov0, 1);
            chk("bp_product", prod0, 4'd3);
            chk("bp_in_ready", ir0, 0);
            chk("bp_rom_en", en0, 0);
            chk("bp_addr_hold", addr0, 4'b0111);
        end
        @(posedge clk); #1;
        iv0 = 1'b0;
        or0 = 1'b1;
        drain0();

`ifdef MULT_LUT_ACC_EN
        acc_clr0 = 1'b1; @(posedge clk); #1; acc_clr0 = 1'b0;
        chk("acc_pre_clear", acc_out0, 0);
        send0(2'd2, 2'd3, 4'd6);
        send0(2'd3, 2'd3, 4'd9);
        send0(2'd2, 2'd2, 4'd4);
        drain0();
        chk("acc_sum_19", acc_out0, 8'd19);
        send0(2'd1, 2'd1, 4'd1);
        acc_clr0 = 1'b1; @(posedge clk); #1; acc_clr0 = 1'b0;
        chk("acc_clr_wins", acc_out0, 0);
        chk("acc_clr_same_capture", ov0, 1);
        drain0();
`endif

        // Instance 1: single result with RD_LAT=3
        send1(2'd3, 2'd3, 4'd9, 1'b0);
        drain1();

        // Back-to-back with in_valid held high
        b2b = 1'b1; last_rise1 = -1;
        send1(2'd2, 2'd3, 4'd6, 1'b1);
        send1(2'd3, 2'd3, 4'd9, 1'b1);
        send1(2'd1, 2'd2, 4'd2, 1'b1);
        send1(2'd3, 2'd1, 4'd3, 1'b0);
        drain1();
        b2b = 1'b0;
        chk("b2b_last_rise_seen", last_rise1 >= 0, 1);
`ifdef MULT_LUT_ACC_EN
        chk("acc1_sum_29", acc_out1, 8'd29);
`endif

        // Reset mid-READ while the counter is still non-zero
        send1(2'd3, 2'd2, 4'd6, 1'b0);
        chk("mid_read_busy", busy1, 1);
        chk("mid_read_rom_en", en1, 1);
        rst1_n = 1'b0;
        #1;
        chk("async_rst_busy1", busy1, 0);
        chk("async_rst_rom_en1", en1, 0);
        chk("async_rst_out_valid1", ov1, 0);
        chk("async_rst_addr1", addr1, 0);
        chk("async_rst_prod1", prod1, 0);
`ifdef MULT_LUT_ACC_EN
        chk("async_rst_acc1", acc_out1, 0);
`endif
        #1;
        rst1_n = 1'b1;
        ovcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov1) ovcnt++;
        end
        chk("no_ov_after_rst", ovcnt, 0);
        chk("in_ready_after_rst", ir1, 1);
        chk("idle_after_rst", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_lut_ctrl.md
MULT_LUT_CTRL -- requirements
Module: mult_lut_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the operand width in bits.
REQ-002 The block SHALL have parameter RD_LAT, default 1, range 1..15, giving the cycles rom_en/rom_read_en are held before rom_data is captured.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-007 The block SHALL have ports a and b, input, N bits each: the unsigned operands.
REQ-008 The block SHALL have port rom_addr, output, 2N bits, equal to {a,b} with a in the MSBs.
REQ-009 The block SHALL have ports rom_en and rom_read_en, output, 1 bit each: the product-ROM enables.
REQ-010 The block SHALL have port rom_data, input, 2N bits: the ROM product, which reads 0 when the ROM is not enabled.
REQ-011 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and product (output, 2N bits): the result handshake.
REQ-012 The block SHALL have port busy, output, 1 bit, asserted when the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, READ and HOLD.
REQ-014 in_ready SHALL equal (state==IDLE) or (state==HOLD and out_ready).
REQ-015 A transfer SHALL occur when in_valid and in_ready are both high; on transfer the block SHALL register {a,b} into rom_addr, load the wait counter with RD_LAT-1, and enter READ.
REQ-016 rom_en and rom_read_en SHALL both be high only in READ; rom_addr SHALL hold its value from transfer until the next transfer.
REQ-017 In READ the counter SHALL decrement each cycle; in the cycle the counter is 0, the block SHALL capture rom_data into product and enter HOLD.
REQ-018 out_valid SHALL be high only in HOLD; product SHALL stay stable while out_valid is high and out_ready is low.
REQ-019 In HOLD with out_ready high and no transfer, the block SHALL return to IDLE.
REQ-020 In HOLD with out_ready high and a simultaneous transfer, the block SHALL go directly to READ, so back-to-back throughput is one result per RD_LAT+1 cycles.
REQ-021 Latency from transfer edge to out_valid high SHALL be RD_LAT+1 cycles when RD_LAT=1, and RD_LAT+1 cycles in general.
REQ-022 in_valid SHALL be ignored outside the in_ready window, and operand changes during READ/HOLD SHALL not affect rom_addr.
REQ-023 The product SHALL be unsigned, 2N bits wide, with no truncation; the maximum value is (2^N-1)^2.

Reset
REQ-024 On rst_n low the block SHALL asynchronously go to IDLE and clear rom_addr, counter and product to 0.
REQ-025 On rst_n low, rom_en, rom_read_en, out_valid and busy SHALL be 0, and in_ready SHALL be 1 once reset is released.
REQ-026 A reset during READ or HOLD SHALL discard the pending result, and no out_valid SHALL follow.

Configuration
REQ-027 When MULT_LUT_ACC_EN is defined, the block SHALL add port acc_clr (input, 1 bit) and port acc_out (output, 2N+4 bits).
REQ-028 With the macro defined, acc_out SHALL add each captured product on the HOLD-entry edge, wrapping modulo 2^(2N+4).
REQ-029 With the macro defined, acc_clr high SHALL zero acc_out on the next edge and SHALL take priority over a simultaneous add; reset SHALL clear acc_out to 0.
REQ-030 When MULT_LUT_ACC_EN is not defined, the acc_clr and acc_out ports and the accumulator logic SHALL be absent, and the block behaviour SHALL otherwise be identical.

Structure
REQ-031 The shared package mult_lut_pkg SHALL hold the state enum (IDLE/READ/HOLD), the default N, the default RD_LAT and the accumulator guard width of 4.
REQ-032 The block SHALL contain no sub-module; the ROM SHALL remain external and be instantiated alongside this block at the next level up.

Verification
REQ-033 The bench SHALL cover single multiply: N=2, RD_LAT=1, a=2, b=3 -> rom_addr=4'b1011, the ROM model returns 6, and product=6 with out_valid 2 cycles after transfer.
REQ-034 The bench SHALL cover the boundary case: a=3, b=3 -> product=9; a=0, b=3 -> product=0.
REQ-035 The bench SHALL cover backpressure: out_ready held low for 5 cycles in HOLD -> product and out_valid stable, in_ready low, and rom_en low.
REQ-036 The bench SHALL cover back-to-back: in_valid held high with out_ready=1 and RD_LAT=3 -> one result every 4 cycles, with no IDLE visits between results.
REQ-037 The bench SHALL cover reset mid-READ: rst_n pulsed low while the counter is non-zero -> IDLE immediately, with no out_valid afterwards and in_ready=1.
REQ-038 With MULT_LUT_ACC_EN defined, the bench SHALL run products 6, 9 and 4 -> acc_out=19, then acc_clr concurrent with a capture -> acc_out=0.
